// File: rtl/uart_tx_queue_pkg.sv
// Shared constants for the UART transmit queue: memory-map addresses,
// default frame time and the scheduler's FSM state encodings.
package uart_tx_queue_pkg;

  localparam logic [31:0] UART_ADDR        = 32'h1000_0000;
  localparam logic [31:0] UART_STATUS_ADDR = UART_ADDR + 32'd4;
  localparam int          UART_BYTE_CYCLES = 1042;

  localparam logic [0:0] TXQ_IDLE = 1'b0;
  localparam logic [0:0] TXQ_WAIT = 1'b1;

  // Bit positions inside the status word
  localparam int STATUS_BUSY_BIT  = 31;
  localparam int STATUS_FULL_BIT  = 30;
  localparam int STATUS_EMPTY_BIT = 29;
  localparam int STATUS_DROP_BIT  = 28;

endpackage

// File: rtl/uart_tx_queue_if.sv
// CPU-store side and serializer side of the transmit queue.
// Handshake: a byte transfers on a rising clk edge where wr_valid && wr_ready;
// the master holds wr_valid/wr_data stable until that edge; uart_wr is a
// one-cycle strobe with no back-pressure and uart_dat is valid only with it.
interface uart_tx_queue_if;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        uart_wr;
  logic [7:0]  uart_dat;
  logic [31:0] status;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready,
    input  uart_wr,
    input  uart_dat,
    input  status
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready,
    output uart_wr,
    output uart_dat,
    output status
  );
endinterface

// File: rtl/uart_tx_queue_fifo.sv
// Synchronous FIFO for the transmit queue: storage, wrapping pointers with an
// extra MSB to tell full from empty, and occupancy level.
module txq_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_queue.sv
// Paced transmit scheduler feeding the uart serializer from a byte FIFO.
// Optional status word and stall watchdog built when UART_TXQ_STATUS_EN is defined.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int BYTE_CYCLES = UART_BYTE_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_tx_queue_if.slave         bus,
  output logic [0:0]             dbg_state,
  output logic [$clog2(DEPTH):0] dbg_level
);
  localparam int CW = (BYTE_CYCLES > 2) ? $clog2(BYTE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(BYTE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = 1;

  logic [0:0]             state;
  logic [CW-1:0]          cnt;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] level;
  logic [7:0]             head;
  logic                   push;
  logic                   issue;

  // Ready comes from registered pointers only, so a pop never frees a slot early
  assign bus.wr_ready = !full;
  assign push         = bus.wr_valid && !full;
  assign issue        = !empty && ((state == TXQ_IDLE) || (cnt == '0));

  txq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.wr_data),
    .pop   (issue),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= TXQ_IDLE;
      cnt          <= '0;
      bus.uart_wr  <= 1'b0;
      bus.uart_dat <= 8'h00;
    end else begin
      bus.uart_wr <= issue;
      if (issue) begin
        bus.uart_dat <= head;
        cnt          <= CNT_RELOAD;
        state        <= TXQ_WAIT;
      end else if (state == TXQ_WAIT) begin
        if (cnt != '0) cnt   <= cnt - CNT_ONE;
        else           state <= TXQ_IDLE;
      end
    end
  end

  assign dbg_state = state;
  assign dbg_level = level;

`ifdef UART_TXQ_STATUS_EN
  logic [12:0] stall_cnt;
  logic        drop;
  logic [31:0] status_q;

  // Watchdog: a store held off for more than 4096 cycles latches drop
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      drop      <= 1'b0;
    end else if (bus.wr_valid && full) begin
      if (stall_cnt == 13'd4096) drop      <= 1'b1;
      else                       stall_cnt <= stall_cnt + 13'd1;
    end else begin
      stall_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= 32'h2000_0000;
    end else begin
      status_q                   <= {16'h0000, 16'(level)};
      status_q[STATUS_BUSY_BIT]  <= (state == TXQ_WAIT);
      status_q[STATUS_FULL_BIT]  <= full;
      status_q[STATUS_EMPTY_BIT] <= empty;
      status_q[STATUS_DROP_BIT]  <= drop;
    end
  end

  assign bus.status = status_q;
`else
  assign bus.status = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with DEPTH=4, BYTE_CYCLES=8: latency,
// burst ordering and spacing, stall release, mid-burst reset, late arrival.
module tb_uart_tx_queue;
  localparam int DEPTH = 4;
  localparam int BC    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:0] dbg_state;
  logic [2:0] dbg_level;

  uart_tx_queue_if bus ();

  uart_tx_queue #(.DEPTH(DEPTH), .BYTE_CYCLES(BC)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_level (dbg_level)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  int         pulse_q[$];
  logic       prev_wr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: every pulse must carry the next expected byte, one cycle wide
  always @(negedge clk) begin
    if (bus.uart_wr === 1'b1) begin
      pulse_q.push_back(cyc);
      check_val("pulse_width", {31'd0, prev_wr}, 32'd0);
      if (exp_q.size() == 0) check_val("unexpected_pulse", {24'd0, bus.uart_dat}, 32'hFFFF_FFFF);
      else                   check_val("uart_dat", {24'd0, bus.uart_dat}, {24'd0, exp_q.pop_front()});
    end
    prev_wr <= bus.uart_wr;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((dbg_state != 1'b0 || dbg_level != 3'd0) && n < 200) begin
      tick();
      n++;
    end
    check_val(tag, {31'd0, n < 200}, 32'd1);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.wr_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check_val(tag, {31'd0, n < 100}, 32'd1);
  endtask

  int t_acc;
  logic any_hi;

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    check_val("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    check_val("rst_uart_wr", {31'd0, bus.uart_wr}, 32'd0);
    check_val("rst_uart_dat", {24'd0, bus.uart_dat}, 32'd0);
    check_val("rst_level", {29'd0, dbg_level}, 32'd0);
    check_val("rst_state", {31'd0, dbg_state}, 32'd0);
`ifdef UART_TXQ_STATUS_EN
    check_val("rst_status", bus.status, 32'h2000_0000);
`else
    check_val("rst_status", bus.status, 32'h0000_0000);
`endif

    // single byte: pulse in the cycle after the edge following acceptance
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h41;
    exp_q.push_back(8'h41);
    pulse_q.delete();
    tick();
    t_acc = cyc;
    bus.wr_valid = 1'b0;
    check_val("single_no_early", {31'd0, bus.uart_wr}, 32'd0);
    check_val("single_level", {29'd0, dbg_level}, 32'd1);
    tick();
    check_val("single_pulse", {31'd0, bus.uart_wr}, 32'd1);
    check_val("single_dat", {24'd0, bus.uart_dat}, 32'h41);
    check_val("single_busy", {31'd0, dbg_state}, 32'd1);
    any_hi = 1'b0;
    for (int i = 0; i < BC - 1; i++) begin
      tick();
      any_hi = any_hi | bus.uart_wr;
    end
    check_val("single_quiet", {31'd0, any_hi}, 32'd0);
    wait_idle("single_idle_timeout");
    check_val("single_pulse_cnt", pulse_q.size(), 32'd1);
    if (pulse_q.size() > 0) check_val("single_latency", pulse_q[0] - t_acc, 32'd1);

    // burst 0x30..0x35 with wr_valid held; stall release on the last byte
    pulse_q.delete();
    bus.wr_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.wr_data = 8'h30 + 8'(k);
      if (k == 5) begin
        wait_ready("stall_timeout");
        check_val("stall_rel_with_pop", {31'd0, bus.uart_wr}, 32'd1);
        check_val("stall_rel_level", {29'd0, dbg_level}, 32'd3);
      end
      exp_q.push_back(8'h30 + 8'(k));
      tick();
      if (k == 0) t_acc = cyc;
      if (k == 4) begin
        check_val("burst_full_ready", {31'd0, bus.wr_ready}, 32'd0);
        check_val("burst_full_level", {29'd0, dbg_level}, 32'd4);
      end
      if (k == 5) begin
        check_val("stall_accept_level", {29'd0, dbg_level}, 32'd4);
        check_val("stall_accept_ready", {31'd0, bus.wr_ready}, 32'd0);
      end
    end
    bus.wr_valid = 1'b0;
    wait_idle("burst_idle_timeout");
    check_val("burst_pulse_cnt", pulse_q.size(), 32'd6);
    check_val("burst_exp_drained", exp_q.size(), 32'd0);
    if (pulse_q.size() > 0) check_val("burst_latency", pulse_q[0] - t_acc, 32'd1);
    for (int i = 1; i < pulse_q.size(); i++) check_val("burst_gap", pulse_q[i] - pulse_q[i-1], BC);

    // reset mid-burst with three bytes still queued
    pulse_q.delete();
    bus.wr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.wr_data = 8'h50 + 8'(k);
      exp_q.push_back(8'h50 + 8'(k));
      tick();
    end
    bus.wr_valid = 1'b0;
    check_val("pre_rst_level", {29'd0, dbg_level}, 32'd3);
    rst = 1'b1;
    tick();
    exp_q.delete();
    check_val("mid_rst_uart_wr", {31'd0, bus.uart_wr}, 32'd0);
    check_val("mid_rst_ready", {31'd0, bus.wr_ready}, 32'd1);
    check_val("mid_rst_level", {29'd0, dbg_level}, 32'd0);
    check_val("mid_rst_state", {31'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    pulse_q.delete();
    repeat (3 * BC) tick();
    check_val("post_rst_pulses", pulse_q.size(), 32'd0);

    // late arrival: second byte pushed 3 cycles after the first pulse
    pulse_q.delete();
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h61;
    exp_q.push_back(8'h61);
    tick();
    bus.wr_valid = 1'b0;
    tick();
    repeat (2) tick();
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h62;
    exp_q.push_back(8'h62);
    tick();
    bus.wr_valid = 1'b0;
    wait_idle("late_idle_timeout");
    check_val("late_pulse_cnt", pulse_q.size(), 32'd2);
    if (pulse_q.size() == 2) check_val("late_gap", pulse_q[1] - pulse_q[0], BC);

`ifdef UART_TXQ_STATUS_EN
    // status lags the queue state by one register stage
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h71;
    exp_q.push_back(8'h71);
    tick();
    bus.wr_data = 8'h72;
    exp_q.push_back(8'h72);
    check_val("status_before", bus.status, 32'h2000_0000);
    tick();
    bus.wr_valid = 1'b0;
    check_val("status_one_queued", bus.status, 32'h0000_0001);
    tick();
    check_val("status_busy", bus.status, 32'h8000_0001);
    wait_idle("status_idle_timeout");
    tick();
    check_val("status_drained", bus.status, 32'h2000_0000);
`endif

    check_val("final_exp_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Buffered, paced transmit scheduler between the CPU's store path to `UART_ADDR` and the `uart` serializer. It accepts bytes from the memory-access stage into a FIFO and issues them to `uart` one at a time, spaced by the serializer's frame time. When the FIFO fills, it back-pressures the CPU so that no character is lost. The existing `uart` module has no busy output, so this block owns its pacing.

## Interface
- `DEPTH`, default 16: FIFO entries; must be a power of two, ≥2.
- `BYTE_CYCLES`, default 1042: clocks per transmitted frame, including start and stop bits; must be ≥2.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `wr_valid` in 1: CPU store to `UART_ADDR` in the MA stage.
- `wr_data` in 8: byte to send, taken from `mem_write_value[7:0]`.
- `wr_ready` out 1: the queue can accept a byte. The CPU holds the MA stage while `wr_valid` is high and `wr_ready` is low.
- `uart_wr` out 1: one-cycle start pulse to `uart.uart_wr_i`.
- `uart_dat` out 8: byte to `uart.uart_dat_i`; valid while `uart_wr` is high.
- `status` out 32: status word; see Configuration.

## Operation
- **Accept rule.** A byte is accepted on a rising edge when `wr_valid && wr_ready`. It is written at `wr_ptr`, and `wr_ptr` increments.
- **Pointers.** `wr_ptr` and `rd_ptr` are each log2(DEPTH)+1 bits and wrap naturally.
  - empty = pointers equal.
  - full = index bits equal and MSBs differ.
  - level = `wr_ptr - rd_ptr`, modulo 2^(log2 DEPTH + 1).
- **`wr_ready`.** Equals `!full` and is computed from registered pointers only. A same-cycle pop never makes a full queue ready.
- **FSM states.**
  - IDLE: if not empty, issue and go to WAIT; otherwise stay.
  - WAIT: if `cnt != 0`, decrement `cnt`. If `cnt == 0` and not empty, issue again and stay in WAIT. If `cnt == 0` and empty, go to IDLE.
- **Issue.** All outputs below are registered:
  - `uart_wr` <= 1;
  - `uart_dat` <= `mem[rd_ptr]`;
  - `rd_ptr`++;
  - `cnt` <= `BYTE_CYCLES-1`.
  - On every edge without an issue, `uart_wr` <= 0.
- **Simultaneous push and pop.** Both are legal in the same cycle when the queue is neither full nor empty; level is then unchanged.
  - Push into an empty queue and a pop in the same edge cannot occur, because the pop is based on the registered empty flag.
- **Reset.** On `rst`, including mid-frame:
  - state = IDLE, pointers = 0, `cnt` = 0;
  - `uart_wr` = 0, `uart_dat` = 0;
  - queued bytes are discarded and `wr_ready` = 1.
  - A frame already handed to `uart` finishes or is reset by `uart`'s own `rst`; this block does not track it.
- **Debug print.** The simulation `$write` of transmitted characters moves here, triggered on the `uart_wr` pulse with `uart_dat`.

## Timing
- **First-byte latency.** A byte accepted at edge t into an empty, IDLE queue produces `uart_wr` high for the cycle after edge t+1.
- **Back-to-back spacing.** Consecutive `uart_wr` pulses are exactly `BYTE_CYCLES` clocks apart while the queue stays non-empty.
- **Minimum idle spacing.** A byte arriving while in WAIT is issued no earlier than `BYTE_CYCLES` clocks after the previous pulse.
- **Pulse width.** `uart_wr` is always exactly 1 cycle.
- **Stall release.** When the queue is full, `wr_ready` rises on the edge after the issue that popped a byte. The held store is then accepted on the following edge.
- **Reset values.**
  - `wr_ready` = 1, `uart_wr` = 0, `uart_dat` = 0.
  - `status` = 0x0000_0000 with the macro off. With the macro on, it equals the empty-queue encoding (empty bit set, level 0).

## Configuration
- **Macro: `UART_TXQ_STATUS_EN`.**
- **Defined.** `status` is registered and updated every cycle:
  - [31] busy (state WAIT);
  - [30] full;
  - [29] empty;
  - [28] drop: sticky; set when `wr_valid && !wr_ready` persists more than 4096 cycles, a stall watchdog; cleared only by `rst`;
  - [15:0] level, zero-extended.
  - CPUTop muxes `status` onto loads from `UART_ADDR+4`, in the same way as the hardware counter.
- **Not defined.** `status` is tied to 0. The watchdog counter and drop flag are not built.

## Structure
- **Shared constants** go in the package header alongside define.v:
  - `UART_ADDR`;
  - `UART_STATUS_ADDR` (`UART_ADDR+4`);
  - default `UART_BYTE_CYCLES`;
  - FSM state encodings `TXQ_IDLE` and `TXQ_WAIT`.
- **Sub-module: `txq_fifo`.** A synchronous FIFO holding storage, pointers, full, empty and level. The top level holds the FSM, pacing counter and status logic.

## Test plan
- **Single byte.** DEPTH=4, BYTE_CYCLES=8. Push 0x41 into an idle queue -> `uart_wr` is high for 1 cycle exactly 1 cycle after acceptance, with `uart_dat`=0x41, then 7 idle cycles.
- **Burst.** Push 0x30..0x35 back-to-back with `wr_valid` held.
  - `wr_ready` drops after 4 bytes are queued with one in flight.
  - All 6 bytes emerge in order, with pulses exactly 8 cycles apart.
- **Stall release.** Hold `wr_valid` while the queue is full -> `wr_ready` returns 1 the cycle after a pop, and the byte is accepted on the next edge with none lost.
- **Reset mid-operation.** Assert `rst` mid-burst with 3 bytes queued -> the next cycle shows `uart_wr`=0, `wr_ready`=1, level 0, and no further pulses.
- **Late arrival.** Push one byte 3 cycles after a pulse -> it issues 8 cycles after the previous pulse, not earlier.
- **Status (macro on).** After 2 pushes with no pops yet -> `status[29]`=0 and level=1 or 2 as appropriate. When drained -> empty=1, busy=0, level=0.
